// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes,
// ExcCode values and Status/Cause bit positions.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

    localparam logic [4:0] EXC_CODE_INT = 5'd0;
    localparam logic [4:0] EXC_CODE_SYS = 5'd8;
    localparam logic [4:0] EXC_CODE_RI  = 5'd10;
    localparam logic [4:0] EXC_CODE_OV  = 5'd12;
    localparam logic [4:0] EXC_CODE_TR  = 5'd13;

    localparam int STATUS_IE   = 0;
    localparam int STATUS_EXL  = 1;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IV    = 23;
    localparam int CAUSE_WP    = 22;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 8;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_EC_LO = 2;

    // ExcCode for the synchronous exception types; 0 otherwise.
    function automatic logic [4:0] exc_code(input logic [31:0] t);
        logic [4:0] c;
        c = EXC_CODE_INT;
        case (t)
            EXC_TYPE_SYS: c = EXC_CODE_SYS;
            EXC_TYPE_RI:  c = EXC_CODE_RI;
            EXC_TYPE_OV:  c = EXC_CODE_OV;
            EXC_TYPE_TR:  c = EXC_CODE_TR;
            default:      c = EXC_CODE_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare pair and sticky timer interrupt.
// Ports: clk, resetn, count_we/compare_we + data_i, count_o, compare_o, timer_int_o.
module cp0_reg_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic hit;

    // Match uses the pre-increment count; Compare==0 disables the timer.
    assign hit = (compare_o != 32'd0) && (count_o == compare_o);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_o     <= 32'd0;
            compare_o   <= 32'd0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we) begin
                count_o <= data_i;
            end else begin
                count_o <= count_o + 32'd1;
            end
            if (compare_we) begin
                compare_o   <= data_i;
                timer_int_o <= 1'b0;
            end else if (hit) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare/Status/Cause/EPC/Config/PRId,
// mtc0 write port, exception state update, timer interrupt, mfc0 read.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] status_n;
    logic [31:0] cause_n;
    logic [31:0] epc_n;
    logic [31:0] epc_tgt;

    cp0_reg_timer u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .count_we    (we_i && (waddr_i == CP0_REG_COUNT)),
        .compare_we  (we_i && (waddr_i == CP0_REG_COMPARE)),
        .data_i      (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );

    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

    assign epc_tgt = is_in_delayslot_i ?
                     current_inst_addr_i - 32'd4 :
                     current_inst_addr_i;

    // mtc0 first, then the exception overrides only the fields it owns.
    always_comb begin
        status_n = status_o;
        cause_n  = cause_o;
        epc_n    = epc_o;
        cause_n[15:10] = int_i;
        if (we_i) begin
            case (waddr_i)
                CP0_REG_STATUS: status_n = data_i;
                CP0_REG_EPC:    epc_n    = data_i;
                CP0_REG_CAUSE: begin
                    cause_n[9:8]     = data_i[9:8];
                    cause_n[CAUSE_WP] = data_i[CAUSE_WP];
                    cause_n[CAUSE_IV] = data_i[CAUSE_IV];
                end
                default: ;
            endcase
        end
        case (excepttype_i)
            EXC_TYPE_INT: begin
                epc_n                         = epc_tgt;
                cause_n[CAUSE_BD]             = is_in_delayslot_i;
                status_n[STATUS_EXL]          = 1'b1;
                cause_n[CAUSE_EC_HI:CAUSE_EC_LO] = EXC_CODE_INT;
            end
            EXC_TYPE_SYS, EXC_TYPE_RI,
            EXC_TYPE_OV, EXC_TYPE_TR: begin
                // Nested exceptions keep the original return point.
                if (!status_o[STATUS_EXL]) begin
                    epc_n             = epc_tgt;
                    cause_n[CAUSE_BD] = is_in_delayslot_i;
                end
                status_n[STATUS_EXL] = 1'b1;
                cause_n[CAUSE_EC_HI:CAUSE_EC_LO] = exc_code(excepttype_i);
            end
            EXC_TYPE_ERET: status_n[STATUS_EXL] = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_o <= STATUS_RESET;
            cause_o  <= 32'd0;
            epc_o    <= 32'd0;
        end else begin
            status_o <= status_n;
            cause_o  <= cause_n;
            epc_o    <= epc_n;
        end
    end

    // No bypass: reads see registered state only.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count_o;
            CP0_REG_COMPARE: data_o = compare_o;
            CP0_REG_STATUS:  data_o = status_o;
            CP0_REG_CAUSE:   data_o = cause_o;
            CP0_REG_EPC:     data_o = epc_o;
            CP0_REG_PRID:    data_o = prid_o;
            CP0_REG_CONFIG:  data_o = config_o;
            default:         data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: stimulus queues tagged expectations,
// a negedge monitor pops and compares them against DUT outputs.
module tb_cp0_reg;

    logic        clk;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk                 (clk),
        .resetn              (resetn),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    localparam int S_COUNT = 0;
    localparam int S_CMP   = 1;
    localparam int S_STAT  = 2;
    localparam int S_CAUSE = 3;
    localparam int S_EPC   = 4;
    localparam int S_CFG   = 5;
    localparam int S_PRID  = 6;
    localparam int S_TIMER = 7;
    localparam int S_DATA  = 8;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   c0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int sel);
        case (sel)
            S_COUNT: return count_o;
            S_CMP:   return compare_o;
            S_STAT:  return status_o;
            S_CAUSE: return cause_o;
            S_EPC:   return epc_o;
            S_CFG:   return config_o;
            S_PRID:  return prid_o;
            S_TIMER: return {31'd0, timer_int_o};
            default: return data_o;
        endcase
    endfunction

    task automatic expect_at(input int tag, input int sel,
                             input logic [31:0] mask,
                             input logic [31:0] exp,
                             input string name);
        chk_t c;
        c.tag = tag; c.sel = sel; c.mask = mask;
        c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk_t c;
        logic [31:0] act;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            c = q.pop_front();
            act = get(c.sel) & c.mask;
            total++;
            if (c.tag != cyc) begin
                bad++;
                $display("FAIL %s: check missed (tag %0d at cycle %0d)",
                         c.name, c.tag, cyc);
            end else if (act !== (c.exp & c.mask)) begin
                bad++;
                $display("FAIL %s: actual=%h required=%h",
                         c.name, act, c.exp & c.mask);
            end
        end
    end

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] EXC_MASK = 32'h8000_007C;

    initial begin
        resetn = 1'b0;
        we_i = 1'b0; waddr_i = '0; data_i = '0;
        raddr_i = 5'd15; int_i = '0; excepttype_i = '0;
        current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;

        repeat (3) tick();
        expect_at(cyc, S_COUNT, ALL, 32'd0, "rst_count");
        expect_at(cyc, S_CMP,   ALL, 32'd0, "rst_compare");
        expect_at(cyc, S_STAT,  ALL, 32'h1000_0000, "rst_status");
        expect_at(cyc, S_CAUSE, ALL, 32'd0, "rst_cause");
        expect_at(cyc, S_EPC,   ALL, 32'd0, "rst_epc");
        expect_at(cyc, S_CFG,   ALL, 32'h0000_8000, "rst_config");
        expect_at(cyc, S_PRID,  ALL, 32'h004C_0102, "rst_prid");
        expect_at(cyc, S_TIMER, ALL, 32'd0, "rst_timer");
        expect_at(cyc, S_DATA,  ALL, 32'h004C_0102, "rd_prid");
        tick();

        // Timer: Compare=20 right after reset.
        resetn = 1'b1;
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd20;
        tick();
        we_i = 1'b0;
        c0 = cyc;
        expect_at(c0,      S_COUNT, ALL, 32'd1,  "cnt_first");
        expect_at(c0 + 19, S_COUNT, ALL, 32'd20, "cnt_at_cmp");
        expect_at(c0 + 19, S_TIMER, ALL, 32'd0,  "tmr_before");
        expect_at(c0 + 20, S_TIMER, ALL, 32'd1,  "tmr_rise");
        expect_at(c0 + 24, S_TIMER, ALL, 32'd1,  "tmr_sticky");
        repeat (24) tick();
        raddr_i = 5'd11;
        expect_at(cyc, S_DATA, ALL, 32'd20, "rd_no_bypass");
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd40;
        expect_at(cyc + 1, S_TIMER, ALL, 32'd0,  "tmr_clear");
        expect_at(cyc + 1, S_COUNT, ALL, 32'd26, "cnt_continue");
        expect_at(cyc + 1, S_DATA,  ALL, 32'd40, "rd_compare");
        tick();

        // Cause write mask, then ignored PRId write, unmapped read.
        waddr_i = 5'd13; data_i = ALL;
        expect_at(cyc + 1, S_CAUSE, ALL, 32'h00C0_0300, "cause_mask");
        tick();
        we_i = 1'b1; waddr_i = 5'd15; data_i = 32'd0;
        int_i = 6'b000001;
        raddr_i = 5'd3;
        expect_at(cyc + 1, S_CAUSE, ALL, 32'h00C0_0700, "cause_ip2");
        expect_at(cyc + 1, S_PRID,  ALL, 32'h004C_0102, "prid_ro");
        expect_at(cyc + 1, S_DATA,  ALL, 32'd0, "rd_unmapped");
        tick();
        we_i = 1'b0; int_i = '0;

        // Syscall in a delay slot, then nested RI.
        excepttype_i = 32'h8;
        current_inst_addr_i = 32'hBFC0_0100;
        is_in_delayslot_i = 1'b1;
        expect_at(cyc + 1, S_EPC,   ALL, 32'hBFC0_00FC, "sys_epc");
        expect_at(cyc + 1, S_CAUSE, EXC_MASK, 32'h8000_0020, "sys_cause");
        expect_at(cyc + 1, S_STAT,  32'h2, 32'h2, "sys_exl");
        tick();
        excepttype_i = 32'ha;
        current_inst_addr_i = 32'h1234_5678;
        is_in_delayslot_i = 1'b0;
        expect_at(cyc + 1, S_EPC,   ALL, 32'hBFC0_00FC, "ri_epc_keep");
        expect_at(cyc + 1, S_CAUSE, EXC_MASK, 32'h8000_0028, "ri_cause");
        tick();

        // ERET.
        excepttype_i = 32'he;
        expect_at(cyc + 1, S_STAT, ALL, 32'h1000_0000, "eret_status");
        expect_at(cyc + 1, S_EPC,  ALL, 32'hBFC0_00FC, "eret_epc");
        tick();

        // mtc0 Status together with an interrupt.
        excepttype_i = 32'h1;
        current_inst_addr_i = 32'h8000_0040;
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_FF01;
        expect_at(cyc + 1, S_STAT,  ALL, 32'h0000_FF03, "int_status");
        expect_at(cyc + 1, S_EPC,   ALL, 32'h8000_0040, "int_epc");
        expect_at(cyc + 1, S_CAUSE, EXC_MASK, 32'd0, "int_cause");
        tick();
        excepttype_i = 32'h0;

        // Compare at all-ones, Count wraps through it.
        waddr_i = 5'd11; data_i = ALL;
        expect_at(cyc + 1, S_TIMER, ALL, 32'd0, "tmr_clear2");
        tick();
        waddr_i = 5'd9; data_i = 32'hFFFF_FFFE;
        expect_at(cyc + 1, S_COUNT, ALL, 32'hFFFF_FFFE, "wrap_0");
        expect_at(cyc + 2, S_COUNT, ALL, 32'hFFFF_FFFF, "wrap_1");
        expect_at(cyc + 3, S_COUNT, ALL, 32'd0, "wrap_2");
        expect_at(cyc + 3, S_TIMER, ALL, 32'd1, "tmr_max");
        tick();
        we_i = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid-run.
        resetn = 1'b0;
        expect_at(cyc, S_COUNT, ALL, 32'd0, "mid_rst_count");
        expect_at(cyc, S_STAT,  ALL, 32'h1000_0000, "mid_rst_status");
        expect_at(cyc, S_TIMER, ALL, 32'd0, "mid_rst_timer");
        expect_at(cyc, S_CMP,   ALL, 32'd0, "mid_rst_compare");
        expect_at(cyc, S_EPC,   ALL, 32'd0, "mid_rst_epc");
        repeat (3) tick();

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: actual=%0d required=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
